alu_issue_ctrl: RTL and testbench

Issue/sequencing stage directly upstream of the 16-bit combinational ALU (opc[2:0], carry-in, result, zero and negative flags). It accepts commands over a valid/ready handshake and holds a 4x16 register file. It drives registered ALU operands, writes the ALU result back, and can repeat an op N times, feeding each result back as the next M operand. It reports the final result and flags on a one-cycle result strobe.

---
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage for the 16-bit combinational ALU.
// This stage accepts load and ALU commands over a valid/ready handshake and holds a small register file.
// It drives registered operands to the ALU and writes each ALU result back.
// An op can repeat rep+1 times, with each result fed back as the next M operand.
// The final result and flags are reported on a one-cycle strobe.
module alu_issue_ctrl #(
    parameter int NREG = 4,
    parameter int REPW = 4,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_ld,
    input  logic [2:0]      cmd_opc,
    input  logic            cmd_cin,
    input  logic [AW-1:0]   cmd_dst,
    input  logic [AW-1:0]   cmd_srcm,
    input  logic [AW-1:0]   cmd_srcn,
    input  logic [REPW-1:0] cmd_rep,
    input  logic [15:0]     cmd_imm,
    output logic [15:0]     alu_m,
    output logic [15:0]     alu_n,
    output logic [2:0]      alu_opc,
    output logic            alu_c,
    input  logic [15:0]     alu_f,
    input  logic            alu_zer,
    input  logic            alu_neg,
    output logic            res_valid,
    output logic [15:0]     res_data,
    output logic            res_zer,
    output logic            res_neg,
    input  logic [AW-1:0]   rd_addr,
    output logic [15:0]     rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [15:0]     regs [NREG];
    logic [AW-1:0]   dst_q;
    logic [REPW-1:0] cnt;
    logic            live;
    logic            acc;

    // cmd_ready stays low during reset and through the first edge after release.
    assign cmd_ready = (state == IDLE) && live;
    assign acc       = cmd_valid && cmd_ready;
    assign res_valid = (state == DONE);
    assign rd_data   = regs[rd_addr];

    // The live flag rises on the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // This process registers the sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: ALU commands run in EXEC until the count expires, then report once in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc && !cmd_ld) state_nx = EXEC;
            EXEC:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: register file writes, ALU operand staging, iteration count and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            alu_m    <= '0;
            alu_n    <= '0;
            alu_opc  <= '0;
            alu_c    <= 1'b0;
            dst_q    <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_zer  <= 1'b0;
            res_neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (cmd_ld) begin
                            regs[cmd_dst] <= cmd_imm;
                        end else begin
                            // N is snapshotted here, so a dst==srcn op keeps the original N value.
                            alu_m   <= regs[cmd_srcm];
                            alu_n   <= regs[cmd_srcn];
                            alu_opc <= cmd_opc;
                            alu_c   <= cmd_cin;
                            dst_q   <= cmd_dst;
                            cnt     <= cmd_rep;
                        end
                    end
                end
                EXEC: begin
                    regs[dst_q] <= alu_f;
                    res_data    <= alu_f;
                    res_zer     <= alu_zer;
                    res_neg     <= alu_neg;
                    if (cnt != '0) begin
                        // Each result feeds back as the next M operand; carry-in applies to the first pass only.
                        cnt   <= cnt - REPW'(1);
                        alu_m <= alu_f;
                        alu_c <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the attached ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_ld;
    logic [2:0]  cmd_opc;
    logic        cmd_cin;
    logic [1:0]  cmd_dst;
    logic [1:0]  cmd_srcm;
    logic [1:0]  cmd_srcn;
    logic [3:0]  cmd_rep;
    logic [15:0] cmd_imm;
    logic [15:0] alu_m;
    logic [15:0] alu_n;
    logic [2:0]  alu_opc;
    logic        alu_c;
    logic [15:0] alu_f;
    logic        alu_zer;
    logic        alu_neg;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_zer;
    logic        res_neg;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] cap_m [16];
    logic [15:0] cap_n [16];
    logic        cap_c [16];
    logic [2:0]  cap_o [16];
    logic        post_valid;
    logic        post_ready;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
        .cmd_opc(cmd_opc), .cmd_cin(cmd_cin), .cmd_dst(cmd_dst),
        .cmd_srcm(cmd_srcm), .cmd_srcn(cmd_srcn), .cmd_rep(cmd_rep), .cmd_imm(cmd_imm),
        .alu_m(alu_m), .alu_n(alu_n), .alu_opc(alu_opc), .alu_c(alu_c),
        .alu_f(alu_f), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .res_valid(res_valid), .res_data(res_data), .res_zer(res_zer), .res_neg(res_neg),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // ALU model: 000 M+N+c, 001 M+(N>>>1)+c, 010 M+1+c, 011 M+(M>>>1)+c,
    // 100 AND, 101 OR, 110 NOT M, 111 clear.
    logic [15:0] shn, shm;
    always_comb begin
        shn   = 16'($signed(alu_n) >>> 1);
        shm   = 16'($signed(alu_m) >>> 1);
        alu_f = '0;
        case (alu_opc)
            3'd0: alu_f = alu_m + alu_n + {15'd0, alu_c};
            3'd1: alu_f = alu_m + shn + {15'd0, alu_c};
            3'd2: alu_f = alu_m + 16'd1 + {15'd0, alu_c};
            3'd3: alu_f = alu_m + shm + {15'd0, alu_c};
            3'd4: alu_f = alu_m & alu_n;
            3'd5: alu_f = alu_m | alu_n;
            3'd6: alu_f = ~alu_m;
            default: alu_f = 16'd0;
        endcase
    end
    assign alu_zer = (alu_f == 16'd0);
    assign alu_neg = alu_f[15];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [1:0] dst, input logic [15:0] imm);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_dst = dst; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_ld = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    // Issues one ALU command and records per-cycle operands until res_valid (lat=-1 on timeout).
    task automatic run_op(input logic [2:0] opc, input logic cin, input logic [1:0] dst,
                          input logic [1:0] srcm, input logic [1:0] srcn, input logic [3:0] rep,
                          output int lat, output int lowcnt, output logic [15:0] rd,
                          output logic rz, output logic rn);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_opc = opc; cmd_cin = cin;
        cmd_dst = dst; cmd_srcm = srcm; cmd_srcn = srcn; cmd_rep = rep;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1; lowcnt = 0; rd = 16'hxxxx; rz = 1'bx; rn = 1'bx;
        for (int n = 0; n < 40; n++) begin
            if (n < 16) begin
                cap_m[n] = alu_m; cap_n[n] = alu_n; cap_c[n] = alu_c; cap_o[n] = alu_opc;
            end
            if (!cmd_ready) lowcnt++;
            if (res_valid) begin
                lat = n; rd = res_data; rz = res_zer; rn = res_neg;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        post_valid = res_valid;
        post_ready = cmd_ready;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", res_valid); end
        total++; if ({alu_m, alu_n, alu_opc, alu_c} !== 36'd0) begin bad++; $display("FAIL rst_alu got=%h want=0", {alu_m, alu_n, alu_opc, alu_c}); end
        total++; if ({res_data, res_zer, res_neg} !== 18'd0) begin bad++; $display("FAIL rst_res got=%h want=0", {res_data, res_zer, res_neg}); end
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            total++; if (v !== 16'd0) begin bad++; $display("FAIL rst_reg%0d got=%h want=0000", a, v); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rel_ready0 got=%b want=0", cmd_ready); end
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rel_ready1 got=%b want=1", cmd_ready); end
    endtask

    task automatic test_add_carry();
        int lat, low; logic [15:0] r, v; logic z, g;
        load(2'd0, 16'd5); load(2'd1, 16'd3);
        rd_reg(2'd0, v);
        total++; if (v !== 16'd5) begin bad++; $display("FAIL ld_r0 got=%h want=0005", v); end
        run_op(3'd0, 1'b1, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({cap_m[0], cap_n[0], cap_c[0], cap_o[0]} !== {16'd5, 16'd3, 1'b1, 3'd0}) begin bad++;
            $display("FAIL add_ops got=%h/%h/%b/%h want=0005/0003/1/0", cap_m[0], cap_n[0], cap_c[0], cap_o[0]); end
        total++; if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d want=1", lat); end
        total++; if ({r, z, g} !== {16'd9, 1'b0, 1'b0}) begin bad++; $display("FAIL add_res got=%h z%b n%b want=0009 z0 n0", r, z, g); end
        total++; if ({post_valid, post_ready} !== 2'b01) begin bad++; $display("FAIL add_post got=%b%b want=01", post_valid, post_ready); end
        rd_reg(2'd2, v);
        total++; if (v !== 16'd9) begin bad++; $display("FAIL add_r2 got=%h want=0009", v); end
    endtask

    task automatic test_carry_once();
        int lat, low; logic [15:0] r; logic z, g;
        load(2'd0, 16'd1); load(2'd1, 16'd2);
        run_op(3'd0, 1'b1, 2'd3, 2'd0, 2'd1, 4'd1, lat, low, r, z, g);
        total++; if ({cap_c[0], cap_c[1]} !== 2'b10) begin bad++; $display("FAIL cy_c got=%b%b want=10", cap_c[0], cap_c[1]); end
        total++; if (cap_m[1] !== 16'd4) begin bad++; $display("FAIL cy_m1 got=%h want=0004", cap_m[1]); end
        total++; if ({lat, r} !== {32'd2, 16'd6}) begin bad++; $display("FAIL cy_res got=%0d/%h want=2/0006", lat, r); end
    endtask

    task automatic test_repeat_wrap();
        int lat, low; logic [15:0] r, v; logic z, g;
        load(2'd0, 16'hFFFC);
        run_op(3'd2, 1'b0, 2'd0, 2'd0, 2'd1, 4'd3, lat, low, r, z, g);
        for (int i = 0; i < 4; i++) begin
            total++; if (cap_m[i] !== 16'hFFFC + 16'(i)) begin bad++; $display("FAIL wrap_m%0d got=%h want=%h", i, cap_m[i], 16'hFFFC + 16'(i)); end
        end
        total++; if (cap_n[3] !== 16'd2) begin bad++; $display("FAIL wrap_n got=%h want=0002", cap_n[3]); end
        total++; if ({r, z, g} !== {16'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL wrap_res got=%h z%b n%b want=0000 z1 n0", r, z, g); end
        total++; if (low !== 5) begin bad++; $display("FAIL wrap_lowrdy got=%0d want=5", low); end
        total++; if (lat !== 4) begin bad++; $display("FAIL wrap_lat got=%0d want=4", lat); end
        rd_reg(2'd0, v);
        total++; if (v !== 16'd0) begin bad++; $display("FAIL wrap_r0 got=%h want=0000", v); end
    endtask

    task automatic test_shift_add();
        int lat, low; logic [15:0] r; logic z, g;
        load(2'd0, 16'd10); load(2'd1, 16'hFFF8);
        run_op(3'd1, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'd6, 1'b0, 1'b0}) begin bad++; $display("FAIL sh1_res got=%h z%b n%b want=0006 z0 n0", r, z, g); end
        load(2'd0, 16'd8);
        run_op(3'd3, 1'b0, 2'd3, 2'd0, 2'd1, 4'd1, lat, low, r, z, g);
        total++; if ({cap_m[0], cap_m[1]} !== {16'd8, 16'd12}) begin bad++; $display("FAIL sh3_m got=%h,%h want=0008,000c", cap_m[0], cap_m[1]); end
        total++; if (r !== 16'h0012) begin bad++; $display("FAIL sh3_res got=%h want=0012", r); end
    endtask

    task automatic test_logic();
        int lat, low; logic [15:0] r; logic z, g;
        load(2'd0, 16'h00F0); load(2'd1, 16'h0FF0);
        run_op(3'd4, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'h00F0, 2'b00}) begin bad++; $display("FAIL and_res got=%h z%b n%b want=00f0 z0 n0", r, z, g); end
        run_op(3'd5, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'h0FF0, 2'b00}) begin bad++; $display("FAIL or_res got=%h z%b n%b want=0ff0 z0 n0", r, z, g); end
        load(2'd0, 16'hFFFF);
        run_op(3'd6, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'h0000, 2'b10}) begin bad++; $display("FAIL not_res got=%h z%b n%b want=0000 z1 n0", r, z, g); end
        run_op(3'd7, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'h0000, 2'b10}) begin bad++; $display("FAIL clr_res got=%h z%b n%b want=0000 z1 n0", r, z, g); end
        load(2'd0, 16'h0001);
        run_op(3'd6, 1'b0, 2'd2, 2'd0, 2'd1, 4'd0, lat, low, r, z, g);
        total++; if ({r, z, g} !== {16'hFFFE, 2'b01}) begin bad++; $display("FAIL neg_res got=%h z%b n%b want=fffe z0 n1", r, z, g); end
    endtask

    task automatic test_handshake();
        logic [15:0] v;
        load(2'd1, 16'h0FF0);
        load(2'd3, 16'h0100);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_opc = 3'd2; cmd_cin = 1'b0;
        cmd_dst = 2'd3; cmd_srcm = 2'd3; cmd_srcn = 2'd0; cmd_rep = 4'd2;
        @(negedge clk);
        cmd_ld = 1'b1; cmd_dst = 2'd1; cmd_imm = 16'hABCD;
        rd_addr = 2'd1;
        for (int n = 0; n < 4; n++) begin
            #1;
            total++; if (rd_data !== 16'h0FF0) begin bad++; $display("FAIL hs_hold%0d got=%h want=0ff0", n, rd_data); end
            if (n == 3) begin
                total++; if ({res_valid, cmd_ready} !== 2'b10) begin bad++; $display("FAIL hs_done got=%b%b want=10", res_valid, cmd_ready); end
            end
            @(negedge clk);
        end
        #1;
        total++; if ({cmd_ready, rd_data} !== {1'b1, 16'h0FF0}) begin bad++; $display("FAIL hs_idle got=%b/%h want=1/0ff0", cmd_ready, rd_data); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_ld = 1'b0;
        #1;
        total++; if (rd_data !== 16'hABCD) begin bad++; $display("FAIL hs_taken got=%h want=abcd", rd_data); end
        rd_reg(2'd3, v);
        total++; if (v !== 16'h0103) begin bad++; $display("FAIL hs_r3 got=%h want=0103", v); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_dst = 2'd0; cmd_imm = 16'h1111;
        @(negedge clk);
        cmd_dst = 2'd1; cmd_imm = 16'h2222;
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 16'h1111) begin bad++; $display("FAIL b2b_r0 got=%h want=1111", rd_data); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_ld = 1'b0;
        rd_addr = 2'd1; #1;
        total++; if (rd_data !== 16'h2222) begin bad++; $display("FAIL b2b_r1 got=%h want=2222", rd_data); end
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 16'h1111) begin bad++; $display("FAIL b2b_r0b got=%h want=1111", rd_data); end
    endtask

    task automatic test_reset_midop();
        logic [15:0] v;
        int seen;
        load(2'd0, 16'd1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_opc = 3'd2; cmd_cin = 1'b1;
        cmd_dst = 2'd0; cmd_srcm = 2'd0; cmd_srcn = 2'd0; cmd_rep = 4'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({cmd_ready, res_valid} !== 2'b00) begin bad++; $display("FAIL mid_ctl got=%b%b want=00", cmd_ready, res_valid); end
        total++; if ({alu_m, alu_n, alu_opc, alu_c} !== 36'd0) begin bad++; $display("FAIL mid_alu got=%h want=0", {alu_m, alu_n, alu_opc, alu_c}); end
        total++; if ({res_data, res_zer, res_neg} !== 18'd0) begin bad++; $display("FAIL mid_res got=%h want=0", {res_data, res_zer, res_neg}); end
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            total++; if (v !== 16'd0) begin bad++; $display("FAIL mid_reg%0d got=%h want=0000", a, v); end
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        rst_n = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_rel0 got=%b want=0", cmd_ready); end
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_rel1 got=%b want=1", cmd_ready); end
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_novalid got=%0d want=0", seen); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_opc = '0; cmd_cin = 1'b0;
        cmd_dst = '0; cmd_srcm = '0; cmd_srcn = '0; cmd_rep = '0; cmd_imm = '0;
        rd_addr = '0; rst_n = 1'b0;
        test_reset();
        test_add_carry();
        test_carry_once();
        test_repeat_wrap();
        test_shift_add();
        test_logic();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
